dm_access_unit: RTL

//  Load/store front-end for the word-only data memory dm_4k.

---
 rtl/dm_access_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dm_access_unit.sv
// Load/store front-end for the word-only data memory dm_4k.
// Byte/half stores are read-modify-write; loads are extended.
module dm_access_unit #(
    parameter int DM_AW = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [1:0]       size,
    input  logic             sign_ext,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             busy,
    output logic             done,
    output logic [31:0]      rdata,
    output logic             misalign,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_din,
    output logic             dm_we,
    input  logic [31:0]      dm_dout
);

    typedef enum logic [2:0] {IDLE, RD, LD, WR, RESP} state_t;

    state_t           state;
    state_t           state_nx;
    logic [DM_AW+1:0] addr_q;
    logic             we_q;
    logic [1:0]       size_q;
    logic             sext_q;
    logic [31:0]      wdata_q;
    logic             legal;
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    logic [31:0]      ld_val;
    logic [31:0]      st_val;
    logic             unused_addr;

    assign unused_addr = ^addr[31:DM_AW+2];

    always_comb begin
        legal = 1'b0;
        unique case (size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~addr[0];
            2'b10:   legal = (addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (!legal)
                        state_nx = RESP;
                    else if (we && size == 2'b10)
                        state_nx = WR;
                    else
                        state_nx = RD;
                end
            end
            RD:      state_nx = we_q ? WR : LD;
            LD:      state_nx = RESP;
            WR:      state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ld_b = dm_dout[7:0];
        unique case (addr_q[1:0])
            2'b00:   ld_b = dm_dout[7:0];
            2'b01:   ld_b = dm_dout[15:8];
            2'b10:   ld_b = dm_dout[23:16];
            default: ld_b = dm_dout[31:24];
        endcase
        ld_h = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];
        ld_val = dm_dout;
        unique case (size_q)
            2'b00:   ld_val = {{24{sext_q & ld_b[7]}}, ld_b};
            2'b01:   ld_val = {{16{sext_q & ld_h[15]}}, ld_h};
            default: ld_val = dm_dout;
        endcase
    end

    // Sub-word stores keep the lanes read back during RD
    always_comb begin
        st_val = dm_dout;
        unique case (size_q)
            2'b00: begin
                unique case (addr_q[1:0])
                    2'b00:   st_val[7:0]   = wdata_q[7:0];
                    2'b01:   st_val[15:8]  = wdata_q[7:0];
                    2'b10:   st_val[23:16] = wdata_q[7:0];
                    default: st_val[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1])
                    st_val[31:16] = wdata_q[15:0];
                else
                    st_val[15:0] = wdata_q[15:0];
            end
            default: st_val = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            sext_q   <= 1'b0;
            wdata_q  <= '0;
            rdata    <= '0;
            misalign <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                addr_q   <= addr[DM_AW+1:0];
                we_q     <= we;
                size_q   <= size;
                sext_q   <= sign_ext;
                wdata_q  <= wdata;
                misalign <= ~legal;
            end
            if (state == LD)
                rdata <= ld_val;
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == RESP);
    assign dm_we   = (state == WR) & ~rst;
    assign dm_din  = (state == WR) ? st_val : 32'h0;
    assign dm_addr = addr_q[DM_AW+1:2];

endmodule
